// File: rtl/add_sub_arbiter.sv
// rtl/add_sub_arbiter.sv - two-requester round-robin front end sharing one add/sub datapath.
// Optional signed-overflow output is enabled by defining ADD_SUB_ARB_OVF_EN.

module add_sub #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  input  logic            sub_i,
  output logic [SIZE-1:0] s_o,
`ifdef ADD_SUB_ARB_OVF_EN
  output logic            ovf_o,
`endif
  output logic            cout_o
);

  logic [SIZE-1:0] b_eff;
  logic [SIZE:0]   sum;

  // Subtract is A + ~B + 1, so cout=1 means no borrow.
  assign b_eff  = sub_i ? ~b_i : b_i;
  assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{SIZE{1'b0}}, sub_i};
  assign s_o    = sum[SIZE-1:0];
  assign cout_o = sum[SIZE];
`ifdef ADD_SUB_ARB_OVF_EN
  assign ovf_o  = (a_i[SIZE-1] == b_eff[SIZE-1]) && (sum[SIZE-1] != a_i[SIZE-1]);
`endif

endmodule

module add_sub_arbiter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  input  logic            req0_sub,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  input  logic            req1_sub,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [SIZE-1:0] res_s,
  output logic            res_cout,
`ifdef ADD_SUB_ARB_OVF_EN
  output logic            res_ovf,
`endif
  output logic            res_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q;
  logic            last_grant_q;
  logic [SIZE-1:0] res_s_q;
  logic            res_cout_q;
  logic            res_id_q;

  logic            grant_id;
  logic            can_accept;
  logic            xfer;
  logic [SIZE-1:0] op_a;
  logic [SIZE-1:0] op_b;
  logic            op_sub;
  logic [SIZE-1:0] dp_s;
  logic            dp_cout;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign can_accept = (state_q == EMPTY) || res_ready;
  assign req0_ready = rst_n && can_accept && req0_valid && !grant_id;
  assign req1_ready = rst_n && can_accept && req1_valid && grant_id;
  assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign op_a   = grant_id ? req1_a   : req0_a;
  assign op_b   = grant_id ? req1_b   : req0_b;
  assign op_sub = grant_id ? req1_sub : req0_sub;

`ifdef ADD_SUB_ARB_OVF_EN
  logic dp_ovf;
  logic res_ovf_q;

  add_sub #(.SIZE(SIZE)) u_add_sub (
    .a_i    (op_a),
    .b_i    (op_b),
    .sub_i  (op_sub),
    .s_o    (dp_s),
    .ovf_o  (dp_ovf),
    .cout_o (dp_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_ovf_q <= 1'b0;
    end else if (xfer) begin
      res_ovf_q <= dp_ovf;
    end
  end

  assign res_ovf = res_ovf_q;
`else
  add_sub #(.SIZE(SIZE)) u_add_sub (
    .a_i    (op_a),
    .b_i    (op_b),
    .sub_i  (op_sub),
    .s_o    (dp_s),
    .cout_o (dp_cout)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      res_s_q      <= '0;
      res_cout_q   <= 1'b0;
      res_id_q     <= 1'b0;
    end else begin
      if (xfer) begin
        res_s_q      <= dp_s;
        res_cout_q   <= dp_cout;
        res_id_q     <= grant_id;
        last_grant_q <= grant_id;
      end
      case (state_q)
        EMPTY: if (xfer) state_q <= FULL;
        FULL:  if (res_ready && !xfer) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_s     = res_s_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_add_sub_arbiter.sv
// tb/tb_add_sub_arbiter.sv - scoreboard bench for add_sub_arbiter (ovf checks when ADD_SUB_ARB_OVF_EN is defined).

module tb_add_sub_arbiter;

  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [SIZE-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic            req0_sub = 1'b0, req1_sub = 1'b0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [SIZE-1:0] res_s;
  logic            res_cout;
  logic            res_id;
`ifdef ADD_SUB_ARB_OVF_EN
  logic            res_ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic            id;
    logic [SIZE-1:0] s;
    logic            cout;
    logic            ovf;
  } res_t;

  res_t sb_q[$];

  always #5 clk = ~clk;

  add_sub_arbiter #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_s      (res_s),
    .res_cout   (res_cout),
`ifdef ADD_SUB_ARB_OVF_EN
    .res_ovf    (res_ovf),
`endif
    .res_id     (res_id)
  );

  function automatic res_t model(input logic id, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                 input logic sub);
    res_t r;
    int sa, sb, sr;
    r.id = id;
    if (sub) begin
      r.s    = a - b;
      r.cout = (a >= b);
    end else begin
      {r.cout, r.s} = {1'b0, a} + {1'b0, b};
    end
    sa = a[SIZE-1] ? int'(a) - (1 << SIZE) : int'(a);
    sb = b[SIZE-1] ? int'(b) - (1 << SIZE) : int'(b);
    sr = sub ? sa - sb : sa + sb;
    r.ovf = (sr > (1 << (SIZE - 1)) - 1) || (sr < -(1 << (SIZE - 1)));
    return r;
  endfunction

  always @(negedge clk) begin
    res_t exp;
    logic ovf_ok;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected got id=%0d s=%h cout=%0d required no result", res_id, res_s, res_cout);
        end else begin
          exp = sb_q.pop_front();
`ifdef ADD_SUB_ARB_OVF_EN
          ovf_ok = (res_ovf === exp.ovf);
`else
          ovf_ok = 1'b1;
`endif
          if (res_id !== exp.id || res_s !== exp.s || res_cout !== exp.cout || !ovf_ok) begin
            errors++;
            $display("FAIL result got id=%0d s=%h cout=%0d required id=%0d s=%h cout=%0d ovf=%0d",
                     res_id, res_s, res_cout, exp.id, exp.s, exp.cout, exp.ovf);
          end
        end
      end
      if (req0_valid && req0_ready) sb_q.push_back(model(1'b0, req0_a, req0_b, req0_sub));
      if (req1_valid && req1_ready) sb_q.push_back(model(1'b1, req1_a, req1_b, req1_sub));
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || res_s !== 4'h0 || res_cout !== 1'b0 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0d s=%h c=%0d id=%0d required 0 0 0 0", res_valid, res_s, res_cout, res_id);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %0d%0d required 00", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_single;
    logic            ids[3]   = '{1'b0, 1'b1, 1'b1};
    logic [SIZE-1:0] as[3]    = '{4'd5, 4'd3, 4'd5};
    logic [SIZE-1:0] bs[3]    = '{4'd3, 4'd5, 4'd3};
    logic            subs[3]  = '{1'b0, 1'b1, 1'b1};
    logic [SIZE-1:0] exp_s[3] = '{4'h8, 4'hE, 4'h2};
    logic            exp_c[3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ids[i]) begin
        req1_valid = 1'b1; req1_a = as[i]; req1_b = bs[i]; req1_sub = subs[i];
      end else begin
        req0_valid = 1'b1; req0_a = as[i]; req0_b = bs[i]; req0_sub = subs[i];
      end
      @(negedge clk);
      checks++;
      if (req0_ready !== !ids[i] || req1_ready !== ids[i]) begin
        errors++;
        $display("FAIL single_ready[%0d] got %0d%0d required id %0d only", i, req0_ready, req1_ready, ids[i]);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_s !== exp_s[i] || res_cout !== exp_c[i] || res_id !== ids[i]) begin
        errors++;
        $display("FAIL single_result[%0d] got v=%0d s=%h c=%0d id=%0d required 1 %h %0d %0d",
                 i, res_valid, res_s, res_cout, res_id, exp_s[i], exp_c[i], ids[i]);
      end
    end
  endtask

  task automatic test_alternate;
    logic g;
    @(posedge clk); #1;
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = SIZE'($urandom); req0_b = SIZE'($urandom); req0_sub = 1'($urandom);
    req1_valid = 1'b1; req1_a = SIZE'($urandom); req1_b = SIZE'($urandom); req1_sub = 1'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g = req1_ready;
      checks++;
      if ((req0_ready ^ req1_ready) !== 1'b1 || g !== 1'(i % 2)) begin
        errors++;
        $display("FAIL alternate_grant[%0d] got %0d%0d required grant %0d", i, req0_ready, req1_ready, i % 2);
      end
      @(posedge clk); #1;
      if (g) begin
        req1_a = SIZE'($urandom); req1_b = SIZE'($urandom); req1_sub = 1'($urandom);
      end else begin
        req0_a = SIZE'($urandom); req0_b = SIZE'($urandom); req0_sub = 1'($urandom);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1;
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd4; req0_sub = 1'b0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_accept got %0d required 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_a = 4'd2; req0_b = 4'd2; req0_sub = 1'b1;
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b1 ||
          res_s !== 4'hD || res_cout !== 1'b0 || res_id !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got rdy=%0d%0d v=%0d s=%h c=%0d id=%0d required 00 1 d 0 0",
                 i, req0_ready, req1_ready, res_valid, res_s, res_cout, res_id);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain_accept got rdy1=%0d v=%0d required 1 1", req1_ready, res_valid);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_id !== 1'b1 || res_s !== 4'h2) begin
      errors++;
      $display("FAIL bp_reload got v=%0d id=%0d s=%h required 1 1 2", res_valid, res_id, res_s);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd1; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd7; req1_sub = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready got %0d%0d required 00", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || res_s !== 4'h0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got v=%0d s=%h rdy=%0d%0d required 0 0 10",
               res_valid, res_s, req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_second got %0d required 1", req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
  endtask

`ifdef ADD_SUB_ARB_OVF_EN
  task automatic test_ovf;
    logic [SIZE-1:0] as[3]    = '{4'd7, 4'd8, 4'd3};
    logic [SIZE-1:0] bs[3]    = '{4'd1, 4'd1, 4'd2};
    logic            subs[3]  = '{1'b0, 1'b1, 1'b0};
    logic [SIZE-1:0] exp_s[3] = '{4'h8, 4'h7, 4'h5};
    logic            exp_o[3] = '{1'b1, 1'b1, 1'b0};
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_a = as[i]; req0_b = bs[i]; req0_sub = subs[i];
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_s !== exp_s[i] || res_ovf !== exp_o[i]) begin
        errors++;
        $display("FAIL ovf[%0d] got v=%0d s=%h ovf=%0d required 1 %h %0d", i, res_valid, res_s, res_ovf, exp_s[i], exp_o[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_reset_mid();
`ifdef ADD_SUB_ARB_OVF_EN
    test_ovf();
`endif
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %0d pending required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_sub_arbiter.md
# add_sub_arbiter

Shares one `add_sub` datapath instance between two independent requesters. Each requester hands over an operand pair and an add/subtract command on a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the result comes back through a single registered output port tagged with the requester ID. The block sits between the two command sources and the downstream result consumer.

## Interface
Parameters:
- `SIZE`, 4, operand and result width in bits (≥2).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0_valid` in 1: requester 0 holds a command.
- `req0_ready` out 1: requester 0 command accepted this cycle.
- `req0_a`, `req0_b` in SIZE: operands for requester 0.
- `req0_sub` in 1: 1 means A−B, 0 means A+B.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`: same as requester 0, for requester 1.
- `res_valid` out 1: result register holds an undelivered result.
- `res_ready` in 1: consumer accepts the result.
- `res_s` out SIZE: sum/difference, modulo 2^SIZE.
- `res_cout` out 1: carry out. For subtract, 1 means no borrow (A ≥ B unsigned).
- `res_id` out 1: requester that issued the result.
- `res_ovf` out 1: signed overflow. Present only with `ADD_SUB_ARB_OVF_EN`.

## Operation
- The block contains exactly one `add_sub #(SIZE)` instance. Its A, B and sub inputs come from the granted requester's operand mux.
- Output stage is a one-entry register.
  - `can_accept = !res_valid || res_ready`.
- Arbitration uses a round-robin pointer `last_grant`.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester ≠ `last_grant` is granted.
  - `reqN_ready = can_accept && grant==N`. It is combinational from the valids, `res_valid` and `res_ready`.
  - At most one `reqN_ready` is high per cycle.
- Handshakes:
  - A transfer occurs on `reqN_valid && reqN_ready`.
  - On a transfer, the result register loads S, Cout, ID (and ovf). `res_valid` goes to 1 and `last_grant` is set to N.
  - `last_grant` updates only on a transfer.
- Drain: `res_valid && res_ready` with no new transfer clears `res_valid`.
  - Drain plus a new transfer in the same cycle reloads the register, and `res_valid` stays 1.
- Backpressure: while `res_valid && !res_ready`:
  - both readys are low;
  - `res_s`, `res_cout`, `res_id` and `res_ovf` are held stable.
- Requesters must hold `valid` and operands until accepted. The block does not store un-granted commands.
- Arithmetic: `res_s = (A + (sub ? ~B : B) + sub) mod 2^SIZE`, and `res_cout` is the carry out of bit SIZE−1.
  - Example, SIZE=4: 3−5 gives `res_s=4'hE`, `res_cout=0`.
- State: `EMPTY` (`res_valid=0`) and `FULL` (`res_valid=1`).
  - EMPTY→FULL on a transfer.
  - FULL→EMPTY on drain without a transfer.
  - FULL→FULL on a hold, or on drain with a transfer.

## Timing
- Reset values (`rst_n`=0 at the clock edge):
  - `res_valid=0`, `res_s=0`, `res_cout=0`, `res_id=0`, `res_ovf=0`.
  - `last_grant=1`, so requester 0 wins the first tie.
- Reset mid-operation: a pending undelivered result is discarded. `res_valid` is 0 the cycle after reset is sampled.
- `reqN_ready` is low during reset cycles, meaning any cycle where `rst_n` is 0.
- Latency: a command accepted at edge k has `res_valid=1` with its result after edge k, so the result is visible in cycle k+1.
- Throughput: one result per cycle while `res_ready` is held 1.
  - Both requesters continuously valid: grants alternate 0,1,0,1.
- Both valid with one grant: the loser sees ready=0 and must hold. It is guaranteed the grant within 2 accepting cycles.

## Configuration
- `ADD_SUB_ARB_OVF_EN` defined:
  - port `res_ovf` exists and is registered with the result, reset to 0.
  - `res_ovf = (A[MSB] == B_eff[MSB]) && (S[MSB] != A[MSB])`, where `B_eff = sub ? ~B : B`.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then req0 A=5 B=3 sub=0, `res_ready=1`:
  - `req0_ready=1` in the request cycle.
  - Next cycle: `res_valid=1`, `res_s=8`, `res_cout=0`, `res_id=0`.
- req1 A=3 B=5 sub=1 gives `res_s=4'hE`, `res_cout=0`, `res_id=1`.
  - Then A=5 B=3 sub=1 gives `res_s=2`, `res_cout=1`.
- Both requesters held valid for 6 cycles, `res_ready=1`:
  - `res_id` sequence is 0,1,0,1,0,1.
  - Exactly one ready per cycle.
- Result pending with `res_ready=0` for 3 cycles:
  - both readys low;
  - `res_*` unchanged.
- Then `res_ready=1` with req1 valid: drain and accept happen in the same cycle, and `res_valid` stays 1 with the new result.
- Assert `rst_n=0` for one cycle while `res_valid=1`: next cycle `res_valid=0`, `res_s=0`, and a tie is won by req0.
- With `ADD_SUB_ARB_OVF_EN`:
  - 7+1 gives `res_s=8`, `res_ovf=1`.
  - 8−1 gives `res_s=7`, `res_ovf=1`.
  - 3+2 gives `res_ovf=0`.
